// File: rtl/msg_decrypt_engine_pkg.sv
// rtl/msg_decrypt_engine_pkg.sv - shared constants, tap table and FSM states for the decrypt engine
package crypt_pkg;

    localparam int ENC_BASE = 64;
    localparam int MSG_LEN  = 64;
    localparam int CHK_LEN  = 9;
    localparam int NUM_TAPS = 9;

    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] PAR_BAD = 8'h80;
    localparam logic [3:0] NO_PTRN = 4'hF;

    localparam logic [6:0] TAP [NUM_TAPS] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                              7'h69, 7'h5C, 7'h7E, 7'h7B};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SEARCH,
        ST_DECRYPT,
        ST_FILL,
        ST_DONE
    } state_t;

    // Out-of-range indices select an all-zero tap rather than wrapping.
    function automatic logic [6:0] tap_sel(input logic [3:0] p);
        tap_sel = 7'h00;
        for (int j = 0; j < NUM_TAPS; j++) begin
            if (p == 4'(j)) tap_sel = TAP[j];
        end
    endfunction

endpackage

// File: rtl/msg_decrypt_engine_if.sv
// rtl/msg_decrypt_engine_if.sv - data-memory read/write port bundle used by the decrypt engine
interface msg_decrypt_engine_if;

    logic [7:0] dm_raddr;
    logic [7:0] dm_rdata;
    logic       dm_wen;
    logic [7:0] dm_waddr;
    logic [7:0] dm_wdata;

    modport master (
        output dm_raddr,
        input  dm_rdata,
        output dm_wen,
        output dm_waddr,
        output dm_wdata
    );

    modport slave (
        input  dm_raddr,
        output dm_rdata,
        input  dm_wen,
        input  dm_waddr,
        input  dm_wdata
    );

endinterface

// File: rtl/msg_decrypt_engine_lfsr7_next.sv
// rtl/msg_decrypt_engine_lfsr7_next.sv - one step of the 7-bit Fibonacci LFSR shared with the encrypt path
module lfsr7_next (
    input  logic [6:0] i_st_in,
    input  logic [6:0] i_tap,
    output logic [6:0] o_st_out
);

    assign o_st_out = {i_st_in[5:0], ^(i_st_in & i_tap)};

endmodule

// File: rtl/msg_decrypt_engine.sv
// rtl/msg_decrypt_engine.sv - recovers LFSR seed/tap from a space preamble, decrypts DM[64:127] into DM[0:63]
module msg_decrypt_engine #(
    parameter int ENC_BASE = crypt_pkg::ENC_BASE,
    parameter int MSG_LEN  = crypt_pkg::MSG_LEN,
    parameter int CHK_LEN  = crypt_pkg::CHK_LEN
) (
    input  logic                 i_clk,
    input  logic                 i_init,
    input  logic                 i_bgn,
    msg_decrypt_engine_if.master dm,
    output logic                 o_ack,
    output logic                 o_err,
    output logic                 o_par_err,
    output logic [3:0]           o_ptrn_idx
);

    import crypt_pkg::*;

    localparam logic [7:0] BASE_ADDR = 8'(ENC_BASE);
    localparam logic [6:0] LAST_I    = 7'(MSG_LEN - 1);
    localparam logic [6:0] W_END     = 7'(MSG_LEN);
    localparam logic [3:0] LAST_K    = 4'(CHK_LEN);
    localparam logic [3:0] LAST_P    = 4'(NUM_TAPS - 1);
    localparam logic [6:0] SPACE7    = SPACE[6:0];

    state_t     r_state;
    logic [6:0] r_seed;
    logic [6:0] r_st;
    logic [6:0] r_i;
    logic [6:0] r_w;
    logic [3:0] r_p;
    logic [3:0] r_k;
    logic [3:0] r_ptrn;
    logic       r_strip;
    logic       r_ack;
    logic       r_err;
    logic       r_par_err;
    logic       r_wen;
    logic [7:0] r_raddr;
    logic [7:0] r_waddr;
    logic [7:0] r_wdata;

    logic [6:0] w_tap;
    logic [6:0] w_st_next;
    logic [6:0] w_rd7;
    logic [6:0] w_key;
    logic       w_match;
    logic       w_par_ok;
    logic [7:0] w_plain;
    logic       w_keep;

    // r_st is the candidate state while searching and the running keystream while decrypting.
    assign w_tap = tap_sel(r_p);

    lfsr7_next u_lfsr (
        .i_st_in (r_st),
        .i_tap   (w_tap),
        .o_st_out(w_st_next)
    );

    assign w_rd7    = dm.dm_rdata[6:0];
    assign w_key    = w_rd7 ^ SPACE7;
    assign w_match  = (w_st_next == w_key);
    assign w_par_ok = (dm.dm_rdata[7] == ^w_rd7);
    assign w_plain  = w_par_ok ? {1'b0, w_rd7 ^ r_st} : PAR_BAD;
    assign w_keep   = !(r_strip && (w_plain == SPACE));

    always_ff @(posedge i_clk or posedge i_init) begin
        if (i_init) begin
            r_state   <= ST_IDLE;
            r_seed    <= '0;
            r_st      <= '0;
            r_i       <= '0;
            r_w       <= '0;
            r_p       <= '0;
            r_k       <= '0;
            r_ptrn    <= NO_PTRN;
            r_strip   <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_par_err <= 1'b0;
            r_wen     <= 1'b0;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
        end else begin
            r_wen <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ack   <= 1'b0;
                    r_raddr <= '0;
                    r_waddr <= '0;
                    r_wdata <= '0;
                    if (!i_bgn) begin
                        r_state   <= ST_SEED;
                        r_err     <= 1'b0;
                        r_par_err <= 1'b0;
                        r_raddr   <= BASE_ADDR;
                    end
                end

                ST_SEED: begin
                    if (w_key == 7'h00) begin
                        r_err   <= 1'b1;
                        r_ptrn  <= NO_PTRN;
                        r_ack   <= 1'b1;
                        r_raddr <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_seed  <= w_key;
                        r_st    <= w_key;
                        r_p     <= '0;
                        r_k     <= 4'd1;
                        r_raddr <= BASE_ADDR + 8'd1;
                        r_state <= ST_SEARCH;
                    end
                end

                ST_SEARCH: begin
                    if (w_match && (r_k == LAST_K)) begin
                        r_ptrn  <= r_p;
                        r_st    <= r_seed;
                        r_i     <= '0;
                        r_w     <= '0;
                        r_strip <= 1'b1;
                        r_raddr <= BASE_ADDR;
                        r_state <= ST_DECRYPT;
                    end else if (w_match) begin
                        r_st    <= w_st_next;
                        r_k     <= r_k + 4'd1;
                        r_raddr <= r_raddr + 8'd1;
                    end else if (r_p == LAST_P) begin
                        r_err   <= 1'b1;
                        r_ptrn  <= NO_PTRN;
                        r_ack   <= 1'b1;
                        r_raddr <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_p     <= r_p + 4'd1;
                        r_st    <= r_seed;
                        r_k     <= 4'd1;
                        r_raddr <= BASE_ADDR + 8'd1;
                    end
                end

                // Writes are registered, so each byte lands in DM one cycle after it is read.
                ST_DECRYPT: begin
                    if (!w_par_ok) r_par_err <= 1'b1;
                    if (w_keep) begin
                        r_wen   <= 1'b1;
                        r_waddr <= {1'b0, r_w};
                        r_wdata <= w_plain;
                        r_w     <= r_w + 7'd1;
                        r_strip <= 1'b0;
                    end
                    r_st <= w_st_next;
                    if (r_i == LAST_I) begin
                        r_raddr <= '0;
                        r_state <= ST_FILL;
                    end else begin
                        r_i     <= r_i + 7'd1;
                        r_raddr <= r_raddr + 8'd1;
                    end
                end

                ST_FILL: begin
                    if (r_w == W_END) begin
                        r_ack   <= 1'b1;
                        r_waddr <= '0;
                        r_wdata <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_wen   <= 1'b1;
                        r_waddr <= {1'b0, r_w};
                        r_wdata <= SPACE;
                        r_w     <= r_w + 7'd1;
                    end
                end

                ST_DONE: begin
                    if (i_bgn) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dm.dm_raddr = r_raddr;
    assign dm.dm_wen   = r_wen;
    assign dm.dm_waddr = r_waddr;
    assign dm.dm_wdata = r_wdata;
    assign o_ack       = r_ack;
    assign o_err       = r_err;
    assign o_par_err   = r_par_err;
    assign o_ptrn_idx  = r_ptrn;

endmodule
